fetch_redirect_ctrl: RTL and testbench

- Sequences the program counter: computes the next fetch address fed to the PC's `addr_in` and drives the PC stall.
- Arbitrates the redirect sources (trap, branch, jump) against sequential +4 fetch.
- Holds a redirect that arrives during a pipeline stall until the stall releases, then flushes IF/ID.
- Sits between the hazard/execute logic and the PC register.

---
 rtl/fetch_redirect_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Next-fetch-address sequencer: arbitrates trap/branch/jump redirects against +4 fetch,
// defers a redirect that arrives under a stall, and drives the PC stall and IF/ID flush.
module fetch_redirect_ctrl #(
    parameter int          INST_MEMORY_SIZE = 16384,
    parameter int          ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
    parameter logic [63:0] RESET_VECTOR     = 64'h0,
    parameter int          BOOT_CYCLES      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic [63:0] cur_pc,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        jump_valid,
    input  logic [63:0] jump_target,
    input  logic        trap_valid,
    input  logic [63:0] trap_target,
    output logic [63:0] next_pc,
    output logic        pc_stall,
    output logic        flush_if_id,
    output logic        misaligned,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        boot_cnt_q, boot_cnt_d;
    logic                    pend_trap_q, pend_trap_d;
    logic [ADDR_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;

    logic                    redirect;
    logic [ADDR_WIDTH-1:0]   live_tgt;
    logic [ADDR_WIDTH-1:0]   rel_tgt;
    logic [ADDR_WIDTH-1:0]   seq_pc;
    logic                    unused_bits;

    // Drops bits above the memory size (wrap) and forces word alignment.
    function automatic logic [63:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
        logic [63:0] r;
        r = '0;
        r[ADDR_WIDTH-1:2] = a[ADDR_WIDTH-1:2];
        return r;
    endfunction

    assign redirect = trap_valid | br_taken | jump_valid;
    assign live_tgt = trap_valid ? trap_target[ADDR_WIDTH-1:0] :
                      br_taken   ? br_target[ADDR_WIDTH-1:0]   :
                                   jump_target[ADDR_WIDTH-1:0];
    // On release only a live trap can beat the deferred entry.
    assign rel_tgt  = trap_valid ? trap_target[ADDR_WIDTH-1:0] : pend_tgt_q;
    assign seq_pc   = cur_pc[ADDR_WIDTH-1:0] + ADDR_WIDTH'(4);
    assign state    = state_q;

    assign unused_bits = ^{cur_pc[63:ADDR_WIDTH], br_target[63:ADDR_WIDTH],
                           jump_target[63:ADDR_WIDTH], trap_target[63:ADDR_WIDTH]};

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pend_trap_d = pend_trap_q;
        pend_tgt_d  = pend_tgt_q;
        next_pc     = align_pc(cur_pc[ADDR_WIDTH-1:0]);
        pc_stall    = 1'b1;
        flush_if_id = 1'b0;
        misaligned  = 1'b0;
        case (state_q)
            BOOT: begin
                next_pc     = align_pc(RESET_VECTOR[ADDR_WIDTH-1:0]);
                flush_if_id = 1'b1;
                boot_cnt_d  = boot_cnt_q + 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = RUN;
                    boot_cnt_d = '0;
                end
            end
            RUN: begin
                if (!stall_in) begin
                    pc_stall = 1'b0;
                    if (redirect) begin
                        next_pc     = align_pc(live_tgt);
                        flush_if_id = 1'b1;
                        misaligned  = |live_tgt[1:0];
                    end else begin
                        next_pc = align_pc(seq_pc);
                    end
                end else if (redirect) begin
                    pend_tgt_d  = live_tgt;
                    pend_trap_d = trap_valid;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (stall_in) begin
                    // A pending trap is only displaced by another trap.
                    if (trap_valid || (redirect && !pend_trap_q)) begin
                        pend_tgt_d  = live_tgt;
                        pend_trap_d = trap_valid;
                    end
                end else begin
                    pc_stall    = 1'b0;
                    flush_if_id = 1'b1;
                    next_pc     = align_pc(rel_tgt);
                    misaligned  = |rel_tgt[1:0];
                    pend_trap_d = 1'b0;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            boot_cnt_q  <= '0;
            pend_trap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pend_trap_q <= pend_trap_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed-vector bench for fetch_redirect_ctrl; expected outputs are queued with each
// vector and a negedge monitor pops and compares them.
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic [63:0] cur_pc;
    logic        br_taken;
    logic [63:0] br_target;
    logic        jump_valid;
    logic [63:0] jump_target;
    logic        trap_valid;
    logic [63:0] trap_target;
    logic [63:0] next_pc;
    logic        pc_stall;
    logic        flush_if_id;
    logic        misaligned;
    logic [1:0]  state;

    fetch_redirect_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall_in    (stall_in),
        .cur_pc      (cur_pc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .next_pc     (next_pc),
        .pc_stall    (pc_stall),
        .flush_if_id (flush_if_id),
        .misaligned  (misaligned),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        stl;
        logic        fl;
        logic        mis;
        logic [1:0]  st;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    task automatic check(input string nm, input string fld, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.nm, "next_pc",     next_pc,             e.pc);
            check(e.nm, "pc_stall",    {63'd0, pc_stall},   {63'd0, e.stl});
            check(e.nm, "flush_if_id", {63'd0, flush_if_id}, {63'd0, e.fl});
            check(e.nm, "misaligned",  {63'd0, misaligned}, {63'd0, e.mis});
            check(e.nm, "state",       {62'd0, state},      {62'd0, e.st});
        end
    end

    // One cycle of stimulus; when chk is set the expected response is queued.
    task automatic step(input logic rst, input logic stl, input logic [63:0] pc,
                        input logic t, input logic [63:0] tt,
                        input logic b, input logic [63:0] bt,
                        input logic j, input logic [63:0] jt,
                        input logic chk, input logic [63:0] epc, input logic es,
                        input logic ef, input logic em, input logic [1:0] est,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        stall_in    = stl;
        cur_pc      = pc;
        trap_valid  = t;
        trap_target = tt;
        br_taken    = b;
        br_target   = bt;
        jump_valid  = j;
        jump_target = jt;
        if (chk) begin
            e.pc = epc; e.stl = es; e.fl = ef; e.mis = em; e.st = est; e.nm = nm;
            sb.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; cur_pc = '0;
        br_taken = 1'b0; br_target = '0; jump_valid = 1'b0; jump_target = '0;
        trap_valid = 1'b0; trap_target = '0;

        // reset and boot
        step(1, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, S_BOOT, "rst");
        step(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 1, 1, 0, S_BOOT, "boot0");
        step(0, 1, 64'h0, 1, 64'h500, 1, 64'h600, 0, 0, 1, 64'h0, 1, 1, 0, S_BOOT, "boot1_ign");
        step(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 64'h4, 0, 0, 0, S_RUN, "run_first");

        // sequential wrap
        step(0, 0, 64'h3FFC, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0, S_RUN, "seq_wrap");

        // source priority
        step(0, 0, 64'h10, 1, 64'h100, 1, 64'h200, 1, 64'h300, 1, 64'h100, 0, 1, 0, S_RUN, "prio_trap");
        step(0, 0, 64'h100, 0, 0, 1, 64'h200, 1, 64'h300, 1, 64'h200, 0, 1, 0, S_RUN, "prio_br");
        step(0, 0, 64'h200, 0, 0, 0, 0, 1, 64'h300, 1, 64'h300, 0, 1, 0, S_RUN, "jump_only");
        step(0, 0, 64'h300, 0, 0, 0, 0, 0, 0, 1, 64'h304, 0, 0, 0, S_RUN, "seq_after");
        step(0, 1, 64'h304, 0, 0, 0, 0, 0, 0, 1, 64'h304, 1, 0, 0, S_RUN, "stall_norm");

        // deferred branch
        step(0, 1, 64'h304, 0, 0, 1, 64'h80, 0, 0, 1, 64'h304, 1, 0, 0, S_RUN, "defer_in");
        step(0, 1, 64'h304, 0, 0, 0, 0, 0, 0, 1, 64'h304, 1, 0, 0, S_HOLD, "hold1");
        step(0, 1, 64'h304, 0, 0, 0, 0, 0, 0, 1, 64'h304, 1, 0, 0, S_HOLD, "hold2");
        step(0, 1, 64'h304, 0, 0, 0, 0, 0, 0, 1, 64'h304, 1, 0, 0, S_HOLD, "hold3");
        step(0, 0, 64'h304, 0, 0, 0, 0, 0, 0, 1, 64'h80, 0, 1, 0, S_HOLD, "release");
        step(0, 0, 64'h80, 0, 0, 0, 0, 0, 0, 1, 64'h84, 0, 0, 0, S_RUN, "after_rel");

        // trap overwrites pending branch
        step(0, 1, 64'h84, 0, 0, 1, 64'h80, 0, 0, 1, 64'h84, 1, 0, 0, S_RUN, "pend_br");
        step(0, 1, 64'h84, 1, 64'h40, 0, 0, 0, 0, 1, 64'h84, 1, 0, 0, S_HOLD, "ovr_trap");
        step(0, 1, 64'h84, 0, 0, 0, 0, 0, 0, 1, 64'h84, 1, 0, 0, S_HOLD, "ovr_wait");
        step(0, 0, 64'h84, 0, 0, 0, 0, 0, 0, 1, 64'h40, 0, 1, 0, S_HOLD, "rel_trap");
        step(0, 0, 64'h40, 0, 0, 0, 0, 0, 0, 1, 64'h44, 0, 0, 0, S_RUN, "after_trap");

        // pending trap survives a jump
        step(0, 1, 64'h44, 1, 64'h40, 0, 0, 0, 0, 1, 64'h44, 1, 0, 0, S_RUN, "pend_trap");
        step(0, 1, 64'h44, 0, 0, 0, 0, 1, 64'h90, 1, 64'h44, 1, 0, 0, S_HOLD, "keep_trap");
        step(0, 0, 64'h44, 0, 0, 0, 0, 0, 0, 1, 64'h40, 0, 1, 0, S_HOLD, "rel_keep");

        // release-cycle arbitration: live trap wins, live branch ignored
        step(0, 1, 64'h40, 0, 0, 1, 64'h80, 0, 0, 1, 64'h40, 1, 0, 0, S_RUN, "pend_br2");
        step(0, 0, 64'h40, 1, 64'h60, 1, 64'hA0, 0, 0, 1, 64'h60, 0, 1, 0, S_HOLD, "rel_live_trap");
        step(0, 1, 64'h60, 0, 0, 0, 0, 1, 64'h120, 1, 64'h60, 1, 0, 0, S_RUN, "pend_jmp");
        step(0, 0, 64'h60, 0, 0, 1, 64'h300, 0, 0, 1, 64'h120, 0, 1, 0, S_HOLD, "rel_live_br");

        // misaligned, wrapped target
        step(0, 0, 64'h120, 0, 0, 1, 64'h10006, 0, 0, 1, 64'h4, 0, 1, 1, S_RUN, "misal_br");
        step(0, 0, 64'h4, 0, 0, 0, 0, 0, 0, 1, 64'h8, 0, 0, 0, S_RUN, "misal_clear");
        step(0, 1, 64'h8, 0, 0, 1, 64'h82, 0, 0, 1, 64'h8, 1, 0, 0, S_RUN, "misal_defer");
        step(0, 0, 64'h8, 0, 0, 0, 0, 0, 0, 1, 64'h80, 0, 1, 1, S_HOLD, "misal_rel");

        // reset in HOLD with a pending trap
        step(0, 1, 64'h80, 1, 64'h40, 0, 0, 0, 0, 1, 64'h80, 1, 0, 0, S_RUN, "rh_pend");
        step(0, 1, 64'h80, 0, 0, 0, 0, 0, 0, 1, 64'h80, 1, 0, 0, S_HOLD, "rh_hold");
        step(1, 1, 64'h80, 0, 0, 0, 0, 0, 0, 1, 64'h80, 1, 0, 0, S_HOLD, "rh_assert");
        step(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 1, 1, 0, S_BOOT, "rh_boot0");
        step(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 1, 1, 0, S_BOOT, "rh_boot1");
        step(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 64'h4, 0, 0, 0, S_RUN, "rh_run");

        begin
            int waited;
            waited = 0;
            while (sb.size() != 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            n_checks++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sb.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
